mem_wb_writeback: RTL and testbench
===================================

Name: mem_wb_writeback

Overview:
- Final pipeline stage of the 5-stage MIPS core.
- Captures the memory-stage result into the MEM/WB pipeline register and selects the writeback value: ALU result, extracted load data, or link address.
- Drives the register file write port (address, data, enable) that the decode stage reads.
- Also provides a retired-instruction counter and a misaligned-load flag.

Parameters:
- COUNT_W, 32, width of the retired-instruction counter; the counter wraps modulo 2^COUNT_W.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  hold the MEM/WB register contents.
- flush  in  1  load a bubble into MEM/WB.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_regwrite  in  1  the instruction writes a register.
- mem_memtoreg  in  1  writeback source is load data.
- mem_link  in  1  writeback source is mem_pc4 (jal/jalr).
- mem_load_type  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; 101-111 treated as LW.
- mem_alu_result  in  32  ALU result; bits [1:0] are the byte offset for loads.
- mem_read_data  in  32  data memory word, big-endian.
- mem_dest_reg  in  5  destination register number.
- mem_pc4  in  32  PC+4 of the instruction.
- wb_reg_write  out  1  register file write enable.
- wb_write_reg  out  5  register file write address.
- wb_write_data  out  32  register file write data.
- wb_valid  out  1  MEM/WB holds a real instruction.
- misalign_err  out  1  the held instruction was a misaligned load.
- retired_count  out  COUNT_W  number of valid instructions captured since reset.

Behaviour:
- Edge priority: rst_n low > flush > stall > capture.
- Reset (rst_n=0 at an edge): all outputs 0, retired_count 0. Reset asserted mid-stall or mid-flush is still plain reset.
- Flush at an edge: wb_valid=0, wb_reg_write=0, misalign_err=0. wb_write_reg and wb_write_data are cleared to 0. Counter unchanged. Flush wins over a simultaneous stall.
- Stall at an edge (no flush): every register holds its value, the counter included. A held write stays asserted on wb_reg_write; re-writing the same value is harmless.
- Capture at an edge: latency is one cycle. Inputs sampled at edge N appear on the outputs after edge N. All selection and extraction happen before the register, so the outputs are pure flops.
- Offset: off = mem_alu_result[1:0]. Big-endian byte b = mem_read_data[31-8*off -: 8]. Halfword h = mem_read_data[31-16*off[1] -: 16].
- Load extraction:
  - LW: the full word.
  - LH: sign-extend h. LHU: zero-extend h.
  - LB: sign-extend b. LBU: zero-extend b.
- Misalignment: true when mem_memtoreg is set and either the type is LW with off != 0, or the type is LH/LHU with off[0] = 1.
- Data select, in priority order: mem_link gives mem_pc4; otherwise mem_memtoreg gives the extracted load; otherwise mem_alu_result.
- Captured values:
  - wb_valid = mem_valid.
  - misalign_err = mem_valid & misaligned.
  - wb_write_reg = mem_dest_reg.
  - wb_write_data = the selected data.
  - wb_reg_write = mem_valid & mem_regwrite & (mem_dest_reg != 0) & ~misaligned. Register $0 is never written.
- Counter: retired_count increments by 1 on every capture edge with mem_valid=1, including misaligned loads and $0 destinations. It wraps from 2^COUNT_W-1 to 0.
- Timing contract: the register file writes on the rising edge while wb_reg_write=1. The decode stage sees the new value in the following cycle; no internal bypass.

Test Plan:
- Reset, then ALU op: mem_valid=1, regwrite=1, dest=8, alu=0x0000_1234 -> one edge later wb_reg_write=1, wb_write_reg=8, wb_write_data=0x0000_1234, retired_count=1.
- Loads, mem_read_data=0x8172_F30A:
  - LB off=2 -> 0xFFFF_FFF3.
  - LBU off=3 -> 0x0000_000A.
  - LH off=0 -> 0xFFFF_8172.
  - LHU off=2 -> 0x0000_F30A.
  - LW off=0 -> 0x8172_F30A.
- Misaligned: LW off=1, or LH off=3 -> wb_reg_write=0, misalign_err=1, wb_valid=1, counter increments.
- $0 and link:
  - dest=0, regwrite=1 -> wb_reg_write=0, counter increments.
  - jal with mem_link=1, mem_pc4=0x0040_0010, dest=31 -> wb_write_data=0x0040_0010, wb_write_reg=31.
- Stall/flush: capture a write, assert stall 3 cycles with new inputs -> outputs and counter frozen. Then assert stall and flush together -> wb_valid=0, wb_reg_write=0, counter unchanged.
- Wrap and reset: COUNT_W=4, 17 valid captures -> retired_count=1. Then drive rst_n=0 for one edge during a stall -> all outputs 0.

Source files
------------

// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback -- MEM/WB pipeline register and writeback stage of the
// 5-stage MIPS core.
//
// Captures the memory-stage result, extracts big-endian load data, selects the
// writeback value (ALU result, load data or link address) and drives the
// register file write port. Also keeps a retired-instruction counter and flags
// misaligned loads. All outputs are driven directly from flops.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   stall, flush      hold the register / load a bubble (flush wins)
//   mem_valid         MEM stage holds a real instruction
//   mem_regwrite      instruction writes a register
//   mem_memtoreg      writeback source is load data
//   mem_link          writeback source is mem_pc4 (jal/jalr)
//   mem_load_type     000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, others LW
//   mem_alu_result    ALU result; [1:0] is the load byte offset
//   mem_read_data     data memory word, big-endian
//   mem_dest_reg      destination register number
//   mem_pc4           PC+4 of the instruction
//   wb_reg_write      register file write enable
//   wb_write_reg      register file write address
//   wb_write_data     register file write data
//   wb_valid          MEM/WB holds a real instruction
//   misalign_err      held instruction was a misaligned load
//   retired_count     valid instructions captured since reset (wraps)
module mem_wb_writeback #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               mem_valid,
  input  logic               mem_regwrite,
  input  logic               mem_memtoreg,
  input  logic               mem_link,
  input  logic [2:0]         mem_load_type,
  input  logic [31:0]        mem_alu_result,
  input  logic [31:0]        mem_read_data,
  input  logic [4:0]         mem_dest_reg,
  input  logic [31:0]        mem_pc4,
  output logic               wb_reg_write,
  output logic [4:0]         wb_write_reg,
  output logic [31:0]        wb_write_data,
  output logic               wb_valid,
  output logic               misalign_err,
  output logic [COUNT_W-1:0] retired_count
);

  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  logic [1:0]         off;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [31:0]        load_data;
  logic               misaligned;

  logic               reg_write_d, reg_write_q;
  logic [4:0]         write_reg_d, write_reg_q;
  logic [31:0]        write_data_d, write_data_q;
  logic               valid_d, valid_q;
  logic               misalign_d, misalign_q;
  logic [COUNT_W-1:0] retired_q;

  // Load extraction and writeback selection, all ahead of the register.
  always_comb begin
    // NOTE: every signal gets a default before the case statements so no
    // path leaves it unassigned; otherwise a latch is inferred.
    off        = mem_alu_result[1:0];
    byte_sel   = mem_read_data[31:24];
    load_data  = mem_read_data;
    misaligned = 1'b0;

    // Big-endian: offset 0 addresses the most significant byte/halfword.
    case (off)
      2'd0:    byte_sel = mem_read_data[31:24];
      2'd1:    byte_sel = mem_read_data[23:16];
      2'd2:    byte_sel = mem_read_data[15:8];
      default: byte_sel = mem_read_data[7:0];
    endcase
    half_sel = off[1] ? mem_read_data[15:0] : mem_read_data[31:16];

    case (mem_load_type)
      LT_LH: begin
        load_data  = {{16{half_sel[15]}}, half_sel};
        misaligned = mem_memtoreg & off[0];
      end
      LT_LHU: begin
        load_data  = {16'h0000, half_sel};
        misaligned = mem_memtoreg & off[0];
      end
      LT_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  load_data = {24'h000000, byte_sel};
      default: begin
        // LW and the unused encodings 101-111.
        load_data  = mem_read_data;
        misaligned = mem_memtoreg & (off != 2'd0);
      end
    endcase

    if (mem_link)          write_data_d = mem_pc4;
    else if (mem_memtoreg) write_data_d = load_data;
    else                   write_data_d = mem_alu_result;

    valid_d     = mem_valid;
    misalign_d  = mem_valid & misaligned;
    write_reg_d = mem_dest_reg;
    // $0 is hard-wired to zero, and a faulting load must not commit.
    reg_write_d = mem_valid & mem_regwrite & (mem_dest_reg != 5'd0) & ~misaligned;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    // NOTE: reset is synchronous; every register, counter included, is
    // cleared when rst_n is low at an edge, ahead of flush and stall.
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
      valid_q      <= 1'b0;
      misalign_q   <= 1'b0;
      retired_q    <= '0;
    end else if (flush) begin
      // Bubble: counter deliberately untouched.
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
      valid_q      <= 1'b0;
      misalign_q   <= 1'b0;
    end else if (!stall) begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      valid_q      <= valid_d;
      misalign_q   <= misalign_d;
      if (mem_valid) retired_q <= retired_q + COUNT_W'(1);
    end
  end

  assign wb_reg_write  = reg_write_q;
  assign wb_write_reg  = write_reg_q;
  assign wb_write_data = write_data_q;
  assign wb_valid      = valid_q;
  assign misalign_err  = misalign_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Testbench for mem_wb_writeback. Two instances share all inputs: one with the
// default 32-bit counter and one with a 4-bit counter to exercise wrapping.
// The driver updates a reference model on every edge and queues the expected
// outputs; a monitor pops and compares one entry after every rising edge.
module tb_mem_wb_writeback;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, flush, mem_valid, mem_regwrite, mem_memtoreg, mem_link;
  logic [2:0]  mem_load_type;
  logic [31:0] mem_alu_result, mem_read_data, mem_pc4;
  logic [4:0]  mem_dest_reg;

  logic        a_rw, a_v, a_mis;
  logic [4:0]  a_wr;
  logic [31:0] a_wd, a_cnt;
  logic        b_rw, b_v, b_mis;
  logic [4:0]  b_wr;
  logic [31:0] b_wd;
  logic [3:0]  b_cnt;

  mem_wb_writeback #(.COUNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
    .mem_memtoreg(mem_memtoreg), .mem_link(mem_link),
    .mem_load_type(mem_load_type), .mem_alu_result(mem_alu_result),
    .mem_read_data(mem_read_data), .mem_dest_reg(mem_dest_reg),
    .mem_pc4(mem_pc4), .wb_reg_write(a_rw), .wb_write_reg(a_wr),
    .wb_write_data(a_wd), .wb_valid(a_v), .misalign_err(a_mis),
    .retired_count(a_cnt)
  );

  mem_wb_writeback #(.COUNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
    .mem_memtoreg(mem_memtoreg), .mem_link(mem_link),
    .mem_load_type(mem_load_type), .mem_alu_result(mem_alu_result),
    .mem_read_data(mem_read_data), .mem_dest_reg(mem_dest_reg),
    .mem_pc4(mem_pc4), .wb_reg_write(b_rw), .wb_write_reg(b_wr),
    .wb_write_data(b_wd), .wb_valid(b_v), .misalign_err(b_mis),
    .retired_count(b_cnt)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        v;
    logic        mis;
    int unsigned cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;            // model of the architecturally visible MEM/WB state
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference rules: shift-and-mask extraction on a big-endian word.
  function automatic int unsigned model_load(input logic [2:0] lt, input int unsigned off,
                                             input int unsigned rd);
    int unsigned b, h;
    b = (rd >> (8 * (3 - off))) & 32'hFF;
    h = (rd >> (16 * (1 - off / 2))) & 32'hFFFF;
    case (lt)
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      default: return rd;
    endcase
  endfunction

  function automatic bit model_misaligned(input bit memtoreg, input logic [2:0] lt,
                                          input int unsigned off);
    if (!memtoreg) return 1'b0;
    if (lt == 3'd1 || lt == 3'd2) return (off % 2) != 0;
    if (lt == 3'd3 || lt == 3'd4) return 1'b0;
    return off != 0;
  endfunction

  // Apply the current inputs for one rising edge, update the model, queue the
  // expected outputs, and return at the following falling edge.
  task automatic tick();
    int unsigned off;
    bit          mis;
    off = mem_alu_result % 4;
    if (!rst_n) begin
      m = '{rw: 0, wr: 0, wd: 0, v: 0, mis: 0, cnt: 0};
    end else if (flush) begin
      m.rw = 0; m.wr = 0; m.wd = 0; m.v = 0; m.mis = 0;
    end else if (!stall) begin
      mis   = model_misaligned(mem_memtoreg, mem_load_type, off);
      m.v   = mem_valid;
      m.mis = mem_valid && mis;
      m.wr  = mem_dest_reg;
      m.rw  = mem_valid && mem_regwrite && mem_dest_reg != 0 && !mis;
      if (mem_link)          m.wd = mem_pc4;
      else if (mem_memtoreg) m.wd = model_load(mem_load_type, off, mem_read_data);
      else                   m.wd = mem_alu_result;
      if (mem_valid) m.cnt = m.cnt + 1;
    end
    sb_q.push_back(m);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic v, input logic rw, input logic m2r, input logic lnk,
                           input logic [2:0] lt, input logic [31:0] alu,
                           input logic [31:0] rd, input logic [4:0] dst,
                           input logic [31:0] pc4);
    mem_valid = v; mem_regwrite = rw; mem_memtoreg = m2r; mem_link = lnk;
    mem_load_type = lt; mem_alu_result = alu; mem_read_data = rd;
    mem_dest_reg = dst; mem_pc4 = pc4;
  endtask

  task automatic load(input logic [2:0] lt, input logic [1:0] off, input logic [4:0] dst);
    set_instr(1, 1, 1, 0, lt, {30'h0000_4000, off}, 32'h8172_F30A, dst, 32'h0000_0100);
    tick();
  endtask

  // Monitor: one expected entry per edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("wb_reg_write",  a_rw,  e.rw);
        check("wb_write_reg",  a_wr,  e.wr);
        check("wb_write_data", a_wd,  e.wd);
        check("wb_valid",      a_v,   e.v);
        check("misalign_err",  a_mis, e.mis);
        check("retired_count", a_cnt, e.cnt);
        check("count4",        b_cnt, e.cnt % 16);
        check("wb_write_data4", b_wd, e.wd);
      end
    end
  end

  initial begin : stimulus
    int guard;
    m = '{rw: 0, wr: 0, wd: 0, v: 0, mis: 0, cnt: 0};
    @(negedge clk);
    rst_n = 0; stall = 0; flush = 0;
    set_instr(1, 1, 0, 0, 3'd0, 32'hDEAD_BEEF, 32'h0, 5'd3, 32'h0);
    tick(); tick();
    check("reset_valid", a_v, 0);
    check("reset_count", a_cnt, 0);

    // ALU op after reset.
    rst_n = 1;
    set_instr(1, 1, 0, 0, 3'd0, 32'h0000_1234, 32'h0, 5'd8, 32'h0);
    tick();
    check("alu_data", a_wd, 32'h0000_1234);
    check("alu_count", a_cnt, 1);

    // Loads from 0x8172_F30A.
    load(3'd3, 2'd2, 5'd9);  check("lb_off2",  a_wd, 32'hFFFF_FFF3);
    load(3'd4, 2'd3, 5'd9);  check("lbu_off3", a_wd, 32'h0000_000A);
    load(3'd1, 2'd0, 5'd9);  check("lh_off0",  a_wd, 32'hFFFF_8172);
    load(3'd2, 2'd2, 5'd9);  check("lhu_off2", a_wd, 32'h0000_F30A);
    load(3'd0, 2'd0, 5'd9);  check("lw_off0",  a_wd, 32'h8172_F30A);
    load(3'd0, 2'd1, 5'd9);  check("lw_off1_mis", a_mis, 1);
    check("lw_off1_nowrite", a_rw, 0);
    load(3'd1, 2'd3, 5'd9);  check("lh_off3_mis", a_mis, 1);
    load(3'd7, 2'd2, 5'd9);  check("lt7_as_lw_mis", a_mis, 1);

    // $0 destination and jal.
    set_instr(1, 1, 0, 0, 3'd0, 32'h5555_0000, 32'h0, 5'd0, 32'h0);
    tick();
    check("r0_nowrite", a_rw, 0);
    set_instr(1, 1, 0, 1, 3'd0, 32'h1111_1111, 32'h0, 5'd31, 32'h0040_0010);
    tick();
    check("jal_data", a_wd, 32'h0040_0010);
    check("jal_reg",  a_wr, 31);

    // Capture a write, then stall 3 cycles with different inputs.
    set_instr(1, 1, 0, 0, 3'd0, 32'hCAFE_0001, 32'h0, 5'd12, 32'h0);
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_instr(1, 1, 0, 0, 3'd0, $urandom, 32'h0, 5'(i + 1), 32'h0);
      tick();
    end
    check("stall_held", a_wd, 32'hCAFE_0001);
    flush = 1;
    tick();
    check("flush_over_stall", a_v, 0);
    stall = 0; flush = 0;

    // Wrap the 4-bit counter: reset, then 17 valid captures.
    rst_n = 0; tick(); rst_n = 1;
    for (int i = 0; i < 17; i++) begin
      set_instr(1, $urandom_range(0, 1), 0, 0, 3'd0, $urandom, 32'h0, 5'($urandom), 32'h0);
      tick();
    end
    check("wrap_count4", b_cnt, 1);
    check("wrap_count32", a_cnt, 17);
    stall = 1; rst_n = 0; tick();
    check("reset_in_stall", a_wd, 0);
    stall = 0; rst_n = 1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) >= 2);
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 10);
      set_instr($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 75,
                $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 15,
                3'($urandom_range(0, 7)), $urandom, $urandom,
                ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom), $urandom);
      tick();
    end

    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
